// File: rtl/matmul_ctrl.sv
// matmul_ctrl -- job sequencer in front of a systolic MAC array.
//
// One job: stream 2*num_macs_p operands from upstream into the array, wait for
// the array to go idle, pulse a flush, then forward num_macs_p results
// downstream and pulse done_o. The operand and result paths are combinational
// pass-throughs gated by state, so neither path adds latency.
//
// Ports
//   clk_i, reset_i             clock, synchronous active-high reset
//   start_i, abort_i           job start (IDLE only) / cancel (any other state)
//   in_valid_i/in_ready_o      upstream operand handshake, in_data_i operand
//   sa_valid_o/sa_ready_i      operand handshake to array, sa_data_o operand
//   sa_busy_i                  array is computing
//   sa_flush_o                 array flush strobe
//   sa_valid_i/sa_yumi_o       result handshake from array, sa_data_i result
//   out_valid_o/out_yumi_i     downstream result handshake, out_data_o result
//   done_o                     one-cycle job-complete pulse
//   state_o                    current state encoding
//   error_o                    watchdog error flag
//
// Build option: define MATMUL_CTRL_WATCHDOG_EN to add a stall watchdog that
// moves the block to ERROR after timeout_p cycles without progress in WAIT or
// DRAIN. Without it ERROR is unreachable and error_o is tied low.
module matmul_ctrl #(
  parameter int width_p        = 8,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int timeout_p      = 1024
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [width_p-1:0] in_data_i,
  output logic               sa_valid_o,
  input  logic               sa_ready_i,
  output logic [width_p-1:0] sa_data_o,
  input  logic               sa_busy_i,
  output logic               sa_flush_o,
  input  logic               sa_valid_i,
  output logic               sa_yumi_o,
  input  logic [width_p-1:0] sa_data_i,
  output logic               out_valid_o,
  input  logic               out_yumi_i,
  output logic [width_p-1:0] out_data_o,
  output logic               done_o,
  output logic [2:0]         state_o,
  output logic               error_o
);
  localparam int num_macs_p = array_width_p * array_height_p;
  localparam int ops_lp     = 2 * num_macs_p;
  localparam int cnt_w_lp   = $clog2(2 * num_macs_p + 1);

  if (timeout_p < 2) begin : g_bad_timeout
    $error("matmul_ctrl: timeout_p must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4,
    ERROR = 3'd5
  } state_e;

  state_e              state;
  logic [cnt_w_lp-1:0] op_cnt, res_cnt;
  logic                done_q, wd_flush, wd_trip;
  logic                in_load, in_drain, op_xfer, res_xfer, op_last, res_last, abort_act;

  // Gating with reset keeps every handshake quiet during the reset cycle
  // itself, so nothing is transferred while progress is being discarded.
  assign in_load   = (state == LOAD) && !reset_i;
  assign in_drain  = (state == DRAIN) && !reset_i;
  assign abort_act = abort_i && (state != IDLE) && !reset_i;
  assign op_xfer   = in_load && in_valid_i && sa_ready_i;
  assign res_xfer  = in_drain && sa_valid_i && out_yumi_i;
  assign op_last   = op_xfer && (op_cnt == cnt_w_lp'(ops_lp - 1));
  assign res_last  = res_xfer && (res_cnt == cnt_w_lp'(num_macs_p - 1));

  assign sa_valid_o  = in_load && in_valid_i;
  assign in_ready_o  = in_load && sa_ready_i;
  assign sa_data_o   = in_data_i;
  assign out_valid_o = in_drain && sa_valid_i;
  assign sa_yumi_o   = res_xfer;
  assign out_data_o  = sa_data_i;
  assign sa_flush_o  = !reset_i && ((state == FLUSH) || abort_act || wd_flush);
  assign done_o      = done_q;
  assign state_o     = state;

`ifdef MATMUL_CTRL_WATCHDOG_EN
  localparam int wd_w_lp = $clog2(timeout_p + 1);
  logic [wd_w_lp-1:0] wd_cnt;
  logic               wd_dwell;

  // Dwell = a cycle in WAIT/DRAIN that neither leaves the state nor moves a
  // result; any other cycle restarts the count.
  assign wd_dwell = ((state == WAIT) && sa_busy_i) || ((state == DRAIN) && !res_xfer);
  assign wd_trip  = !reset_i && !abort_act && wd_dwell &&
                    (wd_cnt == wd_w_lp'(timeout_p - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i || abort_act || !wd_dwell || wd_trip) wd_cnt <= '0;
    else                                              wd_cnt <= wd_cnt + 1'b1;
  end

  assign error_o = (state == ERROR);
`else
  assign wd_trip = 1'b0;
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      op_cnt   <= '0;
      res_cnt  <= '0;
      done_q   <= 1'b0;
      wd_flush <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      wd_flush <= 1'b0;
      if (abort_act) begin
        // Abort beats a simultaneous final transfer: no done pulse.
        state   <= IDLE;
        op_cnt  <= '0;
        res_cnt <= '0;
      end else if (wd_trip) begin
        state    <= ERROR;
        wd_flush <= 1'b1;
      end else begin
        unique case (state)
          IDLE: if (start_i) begin
            state   <= LOAD;
            op_cnt  <= '0;
            res_cnt <= '0;
          end
          LOAD: if (op_xfer) begin
            op_cnt <= op_cnt + 1'b1;
            if (op_last) state <= WAIT;
          end
          WAIT:  if (!sa_busy_i) state <= FLUSH;
          FLUSH: state <= DRAIN;
          DRAIN: if (res_xfer) begin
            res_cnt <= res_cnt + 1'b1;
            if (res_last) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
          ERROR: ;  // held until abort or reset
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_matmul_ctrl.sv
// Randomized bench for matmul_ctrl with a job-level reference model.
module tb_matmul_ctrl;
  localparam int W  = 8;
  localparam int N  = 4;   // 2x2 array
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic         in_valid = 1'b0, sa_ready = 1'b0, sa_busy = 1'b0;
  logic         sa_valid_in = 1'b0, out_yumi = 1'b0;
  logic [W-1:0] in_data = '0, sa_data_in = '0;
  logic         in_ready, sa_valid_o, sa_flush, sa_yumi, out_valid, done, error;
  logic [W-1:0] sa_data_o, out_data;
  logic [2:0]   state;

  always #5 clk = ~clk;

  matmul_ctrl #(.width_p(W), .array_width_p(2), .array_height_p(2), .timeout_p(TO)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .sa_valid_o(sa_valid_o), .sa_ready_i(sa_ready), .sa_data_o(sa_data_o),
    .sa_busy_i(sa_busy), .sa_flush_o(sa_flush),
    .sa_valid_i(sa_valid_in), .sa_yumi_o(sa_yumi), .sa_data_i(sa_data_in),
    .out_valid_o(out_valid), .out_yumi_i(out_yumi), .out_data_o(out_data),
    .done_o(done), .state_o(state), .error_o(error)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus-side array / upstream models ----------------
  logic [W-1:0] rq[$];       // results the array holds, in array order
  logic [W-1:0] exp_res[$];  // what downstream must see for this job
  logic [W-1:0] got[$];      // results seen downstream
  logic [W-1:0] ops_got[$];  // operands seen at the array
  int  p_in = 100, p_rdy = 100, p_yumi = 100, busy_dly = 3, busy_left = 0;
  int  op_seq = 1, op_base = 0, flush_cnt = 0, done_cnt = 0, op_cnt = 0;
  bit  stuck = 1'b0, pop_pending = 1'b0, in_acc = 1'b0;

  task automatic set_arr();
    sa_valid_in = (rq.size() > 0);
    sa_data_in  = (rq.size() > 0) ? rq[0] : '0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    if (pop_pending && rq.size() > 0) void'(rq.pop_front());
    if (!in_valid || in_acc) begin
      if (in_acc) op_seq++;
      in_valid = (int'($urandom_range(99)) < p_in);
    end
    in_data  = W'(op_base + op_seq);
    sa_ready = (int'($urandom_range(99)) < p_rdy);
    out_yumi = (int'($urandom_range(99)) < p_yumi);
    set_arr();
    if (state == 3'd1) begin sa_busy = 1'b1; busy_left = busy_dly; end
    else if (busy_left > 0) begin busy_left--; sa_busy = 1'b1; end
    else sa_busy = stuck;
  endtask

  // ---------------- reference model + compare (negedge) ----------------
  // mp is the spec's state number; mops/mres count handshakes; mrun counts
  // stalled cycles for the watchdog.
  int mp = 0, mops = 0, mres = 0, mrun = 0;
  bit mdone = 1'b0, mwdf = 1'b0;

  always @(negedge clk) begin : monitor
    int np;
    bit xr, ld, dr;
    logic [9:0] ev, av;
    ld = (mp == 1) && !reset;
    dr = (mp == 4) && !reset;
    ev = {ld && sa_ready, ld && in_valid,
          !reset && (mp == 3 || (abort && mp != 0) || mwdf),
          dr && sa_valid_in, dr && sa_valid_in && out_yumi,
          mdone, mp == 5, 3'(mp)};
    av = {in_ready, sa_valid_o, sa_flush, out_valid, sa_yumi, done, error, state};
    chk("ctrl_outputs", 32'(av), 32'(ev));
    if (ld && in_valid)    chk("sa_data", 32'(sa_data_o), 32'(in_data));
    if (dr && sa_valid_in) chk("out_data", 32'(out_data), 32'(sa_data_in));

    // observations used by the stimulus and by the per-job checks
    if (sa_flush) flush_cnt++;
    if (done) done_cnt++;
    if (sa_valid_o && sa_ready) begin op_cnt++; ops_got.push_back(sa_data_o); end
    if (out_valid && out_yumi) got.push_back(out_data);
    pop_pending = sa_yumi;
    in_acc      = in_valid && in_ready;

    if (reset) begin
      mp = 0; mops = 0; mres = 0; mrun = 0; mdone = 1'b0; mwdf = 1'b0;
    end else begin
      np = mp; mdone = 1'b0; mwdf = 1'b0;
      xr = (mp == 4) && sa_valid_in && out_yumi;
      if (abort && mp != 0) begin
        np = 0; mops = 0; mres = 0;
      end else begin
        case (mp)
          0: if (start) begin np = 1; mops = 0; mres = 0; end
          1: if (in_valid && sa_ready) begin mops++; if (mops == 2*N) np = 2; end
          2: if (!sa_busy) np = 3;
          3: np = 4;
          4: if (xr) begin mres++; if (mres == N) begin np = 0; mdone = 1'b1; end end
          default: ;
        endcase
`ifdef MATMUL_CTRL_WATCHDOG_EN
        if ((mp == 2 || mp == 4) && np == mp && !xr) begin
          mrun++;
          if (mrun == TO) begin np = 5; mwdf = 1'b1; end
        end
`endif
      end
      if (np != mp || xr) mrun = 0;
      mp = np;
    end
  end

  // ---------------- scenarios ----------------
  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (state != s && n < budget) begin cyc(); n++; end
    if (state != s) chk(name, 32'(state), 32'(s));
  endtask

  task automatic run_job(input bit dir, input bit with_abort, input int pi, input int pr,
                         input int py, input int bd);
    int d0, f0, o0, n;
    rq.delete(); exp_res.delete(); got.delete(); ops_got.delete();
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] v;
      v = dir ? W'(17 * (i + 1)) : W'($urandom);
      rq.push_back(v); exp_res.push_back(v);
    end
    op_base = dir ? 0 : int'($urandom_range(255)); op_seq = 1;
    p_in = pi; p_rdy = pr; p_yumi = py; busy_dly = bd;
    set_arr();
    d0 = done_cnt; f0 = flush_cnt; o0 = op_cnt;
    start = 1'b1; abort = with_abort;
    cyc();
    start = 1'b0; abort = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 500) begin cyc(); n++; end
    cyc(); cyc();
    chk("job_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("job_operands", 32'(op_cnt - o0), 32'(2 * N));
    chk("job_flushes", 32'(flush_cnt - f0), 32'd1);
    chk("job_result_count", 32'(got.size()), 32'(N));
    for (int i = 0; i < N && i < got.size(); i++)
      chk("job_result_order", 32'(got[i]), 32'(exp_res[i]));
    chk("job_end_state", 32'(state), 32'd0);
  endtask

  initial begin
    int d0, f0, o0, n;
    set_arr();
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outputs", 32'({in_ready, sa_valid_o, sa_flush, out_valid, sa_yumi, done, error}), 32'd0);
    repeat (2) cyc();

    // directed normal job: operands 1..8, results 0x11..0x44
    run_job(1'b1, 1'b0, 100, 100, 100, 3);
    chk("dir_res0", 32'(got.size() > 0 ? got[0] : 8'h0), 32'h11);
    chk("dir_res3", 32'(got.size() > 3 ? got[3] : 8'h0), 32'h44);
    chk("dir_op0", 32'(ops_got.size() > 0 ? ops_got[0] : 8'h0), 32'h01);
    chk("dir_op7", 32'(ops_got.size() > 7 ? ops_got[7] : 8'h0), 32'h08);

    // backpressure: 50% ready in LOAD, downstream stalled in DRAIN
    run_job(1'b1, 1'b0, 100, 50, 30, 2);

    // start together with abort in IDLE still starts
    run_job(1'b0, 1'b1, 80, 70, 70, 1);

    // abort on the 5th operand cycle
    rq.delete(); set_arr();
    p_in = 100; p_rdy = 100; p_yumi = 100; op_seq = 1;
    d0 = done_cnt; o0 = op_cnt;
    start = 1'b1; cyc(); start = 1'b0;
    n = 0;
    while (op_cnt - o0 < 4 && n < 50) begin cyc(); n++; end
    abort = 1'b1;
    @(negedge clk);
    chk("abort_flush", 32'(sa_flush), 32'd1);
    cyc(); abort = 1'b0;
    chk("abort_idle", 32'(state), 32'd0);
    repeat (3) cyc();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_job(1'b0, 1'b0, 100, 100, 100, 2);

    // reset in DRAIN after two results
    rq.delete(); exp_res.delete(); got.delete();
    for (int i = 0; i < N; i++) rq.push_back(W'($urandom));
    set_arr();
    p_yumi = 100; d0 = done_cnt;
    start = 1'b1; cyc(); start = 1'b0;
    n = 0;
    while (got.size() < 2 && n < 200) begin cyc(); n++; end
    chk("pre_reset_drain", 32'(state), 32'd4);
    reset = 1'b1; cyc(); reset = 1'b0;
    rq.delete(); set_arr();
    @(negedge clk);
    chk("post_reset_outputs",
        32'({in_ready, sa_valid_o, sa_flush, out_valid, sa_yumi, done, error, state}), 32'd0);
    repeat (3) cyc();
    chk("reset_no_done", 32'(done_cnt - d0), 32'd0);

    // randomized jobs
    for (int j = 0; j < 20; j++)
      run_job(1'b0, 1'b0, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
              int'($urandom_range(30, 100)), int'($urandom_range(0, 6)));

    // random aborts at random points, then clean up the array
    for (int j = 0; j < 10; j++) begin
      rq.delete();
      for (int i = 0; i < N; i++) rq.push_back(W'($urandom));
      set_arr();
      p_in = 70; p_rdy = 70; p_yumi = 70; busy_dly = int'($urandom_range(0, 4));
      start = 1'b1; cyc(); start = 1'b0;
      repeat ($urandom_range(1, 25)) cyc();
      abort = 1'b1; cyc(); abort = 1'b0;
      chk("rand_abort_idle", 32'(state), 32'd0);
      rq.delete(); set_arr();
      cyc();
    end

    // array stuck busy
    rq.delete(); set_arr();
    stuck = 1'b1; p_in = 100; p_rdy = 100; busy_dly = 0;
    start = 1'b1; cyc(); start = 1'b0;
    wait_state(3'd2, 50, "reach_wait");
    f0 = flush_cnt;
    repeat (TO + 4) cyc();
    start = 1'b1; cyc(); start = 1'b0;
`ifdef MATMUL_CTRL_WATCHDOG_EN
    chk("wd_state", 32'(state), 32'd5);
    chk("wd_error", 32'(error), 32'd1);
    chk("wd_flushes", 32'(flush_cnt - f0), 32'd1);
`else
    chk("nowd_state", 32'(state), 32'd2);
    chk("nowd_error", 32'(error), 32'd0);
    chk("nowd_flushes", 32'(flush_cnt - f0), 32'd0);
`endif
    abort = 1'b1; cyc(); abort = 1'b0; stuck = 1'b0;
    chk("stuck_abort_idle", 32'(state), 32'd0);
    chk("stuck_abort_error", 32'(error), 32'd0);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
